// File: rtl/board_renderer_pkg.sv
// Shared definitions for the board renderer:
// copy-engine source codes, screen geometry and FSM states.
package board_renderer_pkg;

    localparam logic [1:0] MS_TITLE = 2'b00;
    localparam logic [1:0] MS_GAME  = 2'b01;
    localparam logic [1:0] MS_END   = 2'b10;
    localparam logic [1:0] MS_TILE  = 2'b11;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int TILE_PX  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BG_ISSUE,
        ST_BG_WAIT,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/board_renderer_tile_map_store.sv
// Tile map plus per-cell dirty bits, with a write/compare port,
// a scan port that can clear its cell, and a collision read port.
module tile_map_store
    import board_renderer_pkg::*;
#(
    parameter int COLS = 15,
    parameter int ROWS = 13
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_we,
    input  logic [3:0] i_wcol,
    input  logic [3:0] i_wrow,
    input  logic [3:0] i_wtile,
    input  logic [3:0] i_rd_col,
    input  logic [3:0] i_rd_row,
    output logic [3:0] o_rd_tile,
    input  logic [3:0] i_sc_col,
    input  logic [3:0] i_sc_row,
    output logic [3:0] o_sc_tile,
    output logic       o_sc_dirty,
    input  logic       i_clr,
    input  logic       i_set_all,
    output logic       o_any_dirty
);

    localparam int N  = COLS * ROWS;
    localparam int IW = $clog2(N);

    logic [3:0]    r_map [N];
    logic [N-1:0]  r_dirty;
    logic [N-1:0]  w_dirty_nxt;
    logic          w_wr_ok;
    logic          w_rd_ok;
    logic          w_wr_set;
    logic [IW-1:0] w_widx;
    logic [IW-1:0] w_ridx;
    logic [IW-1:0] w_sidx;

    function automatic logic [IW-1:0] idx_of(
        input logic [3:0] c,
        input logic [3:0] r
    );
        return IW'(r) * IW'(COLS) + IW'(c);
    endfunction

    assign w_widx = idx_of(i_wcol, i_wrow);
    assign w_ridx = idx_of(i_rd_col, i_rd_row);
    assign w_sidx = idx_of(i_sc_col, i_sc_row);

    assign w_wr_ok = i_we
                   && ({1'b0, i_wcol} < 5'(COLS))
                   && ({1'b0, i_wrow} < 5'(ROWS));
    assign w_rd_ok = ({1'b0, i_rd_col} < 5'(COLS))
                   && ({1'b0, i_rd_row} < 5'(ROWS));

    // a cell only becomes dirty when its stored tile really changes
    assign w_wr_set = w_wr_ok && (r_map[w_widx] != i_wtile);

    assign o_rd_tile   = w_rd_ok ? r_map[w_ridx] : 4'd0;
    assign o_sc_tile   = r_map[w_sidx];
    assign o_sc_dirty  = r_dirty[w_sidx];
    assign o_any_dirty = |r_dirty;

    // next dirty vector: set-all, then scan clear, then write set (set wins)
    always_comb begin
        w_dirty_nxt = i_set_all ? '1 : r_dirty;
        if (i_clr) begin
            w_dirty_nxt[w_sidx] = 1'b0;
        end
        if (w_wr_set) begin
            w_dirty_nxt[w_widx] = 1'b1;
        end
    end

    // dirty-bit register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= w_dirty_nxt;
        end
    end

    // tile map storage, written by game logic
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                r_map[i] <= 4'd0;
            end
        end else if (w_wr_ok) begin
            r_map[w_widx] <= i_wtile;
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Board renderer: walks the tile map and issues one copy per dirty
// cell, preceded by a game-background copy whenever a redraw is pending.
module board_renderer
    import board_renderer_pkg::*;
#(
    parameter int COLS     = 15,
    parameter int ROWS     = 13,
    parameter int TILE     = 16,
    parameter int ORIGIN_X = 40,
    parameter int ORIGIN_Y = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cell_we,
    input  logic [3:0] cell_col,
    input  logic [3:0] cell_row,
    input  logic [3:0] cell_tile,
    input  logic [3:0] rd_col,
    input  logic [3:0] rd_row,
    output logic [3:0] rd_tile,
    input  logic       redraw_all,
    output logic       copy_go,
    output logic [1:0] copy_memory_select,
    output logic [3:0] copy_tile_select,
    output logic [8:0] copy_x,
    output logic [7:0] copy_y,
    input  logic       copy_finished,
    output logic       busy,
    output logic       frame_done
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_col;
    logic [3:0] w_col_nxt;
    logic [3:0] r_row;
    logic [3:0] w_row_nxt;
    logic       r_pend;
    logic       w_pend_nxt;
    logic [1:0] r_ms;
    logic [1:0] w_ms_nxt;
    logic [3:0] r_tile;
    logic [3:0] w_tile_nxt;
    logic [8:0] r_x;
    logic [8:0] w_x_nxt;
    logic [7:0] r_y;
    logic [7:0] w_y_nxt;
    logic       w_last;
    logic       w_clr;
    logic       w_set_all;
    logic [3:0] w_sc_tile;
    logic       w_sc_dirty;
    logic       w_any_dirty;

    tile_map_store #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_store (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_we        (cell_we),
        .i_wcol      (cell_col),
        .i_wrow      (cell_row),
        .i_wtile     (cell_tile),
        .i_rd_col    (rd_col),
        .i_rd_row    (rd_row),
        .o_rd_tile   (rd_tile),
        .i_sc_col    (r_col),
        .i_sc_row    (r_row),
        .o_sc_tile   (w_sc_tile),
        .o_sc_dirty  (w_sc_dirty),
        .i_clr       (w_clr),
        .i_set_all   (w_set_all),
        .o_any_dirty (w_any_dirty)
    );

    assign w_last = (r_col == 4'(COLS - 1)) && (r_row == 4'(ROWS - 1));

    assign copy_go            = (r_state == ST_ISSUE)
                             || (r_state == ST_BG_ISSUE);
    assign busy               = (r_state != ST_IDLE);
    assign frame_done         = (r_state == ST_DONE);
    assign copy_memory_select = r_ms;
    assign copy_tile_select   = r_tile;
    assign copy_x             = r_x;
    assign copy_y             = r_y;

    // next-state logic; copy fields are latched one cycle ahead of go
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pend_nxt  = r_pend | redraw_all;
        w_ms_nxt    = r_ms;
        w_tile_nxt  = r_tile;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_clr       = 1'b0;
        w_set_all   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pend) begin
                    w_ms_nxt    = MS_GAME;
                    w_tile_nxt  = 4'd0;
                    w_x_nxt     = 9'd0;
                    w_y_nxt     = 8'd0;
                    w_state_nxt = ST_BG_ISSUE;
                end else if (w_any_dirty) begin
                    w_col_nxt   = 4'd0;
                    w_row_nxt   = 4'd0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_BG_ISSUE: begin
                w_pend_nxt  = redraw_all;
                w_state_nxt = ST_BG_WAIT;
            end
            ST_BG_WAIT: begin
                if (copy_finished) begin
                    w_set_all   = 1'b1;
                    w_col_nxt   = 4'd0;
                    w_row_nxt   = 4'd0;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_sc_dirty) begin
                    w_clr       = 1'b1;
                    w_ms_nxt    = MS_TILE;
                    w_tile_nxt  = w_sc_tile;
                    w_x_nxt     = 9'(ORIGIN_X) + 9'(r_col) * 9'(TILE);
                    w_y_nxt     = 8'(ORIGIN_Y) + 8'(r_row) * 8'(TILE);
                    w_state_nxt = ST_ISSUE;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else if (r_col == 4'(COLS - 1)) begin
                    w_col_nxt = 4'd0;
                    w_row_nxt = r_row + 4'd1;
                end else begin
                    w_col_nxt = r_col + 4'd1;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (copy_finished) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SCAN;
                        if (r_col == 4'(COLS - 1)) begin
                            w_col_nxt = 4'd0;
                            w_row_nxt = r_row + 4'd1;
                        end else begin
                            w_col_nxt = r_col + 4'd1;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // state, scan position, pending flag and copy-field registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_col   <= 4'd0;
            r_row   <= 4'd0;
            r_pend  <= 1'b1;
            r_ms    <= MS_TILE;
            r_tile  <= 4'd0;
            r_x     <= 9'd0;
            r_y     <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_pend  <= w_pend_nxt;
            r_ms    <= w_ms_nxt;
            r_tile  <= w_tile_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Self-checking bench for board_renderer: a copy-engine model, a
// reference tile map and a model of what has been painted on screen.
module tb_board_renderer;

    localparam int COLS = 15;
    localparam int ROWS = 13;
    localparam int N    = COLS * ROWS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cell_we;
    logic [3:0] cell_col;
    logic [3:0] cell_row;
    logic [3:0] cell_tile;
    logic [3:0] rd_col;
    logic [3:0] rd_row;
    logic [3:0] rd_tile;
    logic       redraw_all;
    logic       copy_go;
    logic [1:0] copy_memory_select;
    logic [3:0] copy_tile_select;
    logic [8:0] copy_x;
    logic [7:0] copy_y;
    logic       copy_finished;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    board_renderer dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cell_we            (cell_we),
        .cell_col           (cell_col),
        .cell_row           (cell_row),
        .cell_tile          (cell_tile),
        .rd_col             (rd_col),
        .rd_row             (rd_row),
        .rd_tile            (rd_tile),
        .redraw_all         (redraw_all),
        .copy_go            (copy_go),
        .copy_memory_select (copy_memory_select),
        .copy_tile_select   (copy_tile_select),
        .copy_x             (copy_x),
        .copy_y             (copy_y),
        .copy_finished      (copy_finished),
        .busy               (busy),
        .frame_done         (frame_done)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mdl[N];
    int scr[N];
    int q_ms[$];
    int q_tile[$];
    int q_x[$];
    int q_y[$];
    int q_fr[$];
    int frames = 0;
    int eng_cnt = 0;
    int eng_delay = 5;
    bit rand_delay = 0;
    bit busy_seen = 0;

    // copy-engine model and transaction/screen monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            eng_cnt = 0;
            copy_finished = 1'b0;
        end else begin
            copy_finished = 1'b0;
            if (busy) busy_seen = 1'b1;
            if (copy_go) begin
                int c;
                int r;
                q_ms.push_back(int'(copy_memory_select));
                q_tile.push_back(int'(copy_tile_select));
                q_x.push_back(int'(copy_x));
                q_y.push_back(int'(copy_y));
                q_fr.push_back(frames);
                if (copy_memory_select == 2'b01) begin
                    foreach (scr[i]) scr[i] = -1;
                end else begin
                    c = (int'(copy_x) - 40) / 16;
                    r = (int'(copy_y) - 16) / 16;
                    if (c >= 0 && c < COLS && r >= 0 && r < ROWS)
                        scr[r * COLS + c] = int'(copy_tile_select);
                end
                eng_cnt = rand_delay ? int'($urandom_range(1, 6)) : eng_delay;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) copy_finished = 1'b1;
            end
            if (frame_done) frames++;
        end
    end

    task automatic clear_q();
        q_ms.delete();
        q_tile.delete();
        q_x.delete();
        q_y.delete();
        q_fr.delete();
    endtask

    task automatic write_cell(input int c, input int r, input int t);
        @(negedge clk);
        cell_we   = 1'b1;
        cell_col  = 4'(c);
        cell_row  = 4'(r);
        cell_tile = 4'(t);
        if (c < COLS && r < ROWS) mdl[r * COLS + c] = t;
        @(negedge clk);
        cell_we = 1'b0;
    endtask

    task automatic wait_frames(input int k, input int bound);
        int f0;
        int cyc;
        f0 = frames;
        cyc = 0;
        while (frames < f0 + k && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (frames < f0 + k) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_frames: got %0d frames, required %0d",
                     frames - f0, k);
        end
    endtask

    task automatic wait_idle(input int bound);
        int quiet;
        int cyc;
        quiet = 0;
        cyc = 0;
        while (quiet < 4 && cyc < bound) begin
            @(negedge clk);
            quiet = busy ? 0 : quiet + 1;
            cyc++;
        end
        if (quiet < 4) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: busy=%0b after %0d cycles", busy, cyc);
        end
    endtask

    task automatic wait_go(input int bound);
        int cyc;
        cyc = 0;
        while (copy_go !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        if (copy_go !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_go: no copy_go within %0d cycles", bound);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rd_col = 4'd3;
        rd_row = 4'd2;
        repeat (3) @(negedge clk);
        n_cmp += 8;
        if (copy_go !== 1'b0) begin
            n_err++; $display("FAIL rst_go: got %b need 0", copy_go);
        end
        if (copy_memory_select !== 2'b11) begin
            n_err++; $display("FAIL rst_ms: got %b need 11", copy_memory_select);
        end
        if (copy_tile_select !== 4'd0) begin
            n_err++; $display("FAIL rst_tile: got %0d need 0", copy_tile_select);
        end
        if (copy_x !== 9'd0) begin
            n_err++; $display("FAIL rst_x: got %0d need 0", copy_x);
        end
        if (copy_y !== 8'd0) begin
            n_err++; $display("FAIL rst_y: got %0d need 0", copy_y);
        end
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL rst_busy: got %b need 0", busy);
        end
        if (frame_done !== 1'b0) begin
            n_err++; $display("FAIL rst_fd: got %b need 0", frame_done);
        end
        if (rd_tile !== 4'd0) begin
            n_err++; $display("FAIL rst_rd: got %0d need 0", rd_tile);
        end
    endtask

    task automatic test_full_redraw();
        int f0;
        clear_q();
        f0 = frames;
        @(negedge clk);
        reset_n = 1'b1;
        wait_frames(1, 5000);
        wait_idle(200);
        n_cmp++;
        if (q_ms.size() != N + 1) begin
            n_err++;
            $display("FAIL full_count: got %0d gos need %0d", q_ms.size(), N + 1);
        end
        if (q_ms.size() > 0) begin
            n_cmp++;
            if (q_ms[0] != 1 || q_x[0] != 0 || q_y[0] != 0) begin
                n_err++;
                $display("FAIL full_bg: got ms %0d x %0d y %0d need 1 0 0",
                         q_ms[0], q_x[0], q_y[0]);
            end
        end
        for (int i = 1; i < q_ms.size() && i <= N; i++) begin
            int c;
            int r;
            c = (i - 1) % COLS;
            r = (i - 1) / COLS;
            n_cmp++;
            if (q_ms[i] != 3 || q_tile[i] != mdl[i - 1]
                || q_x[i] != 40 + c * 16 || q_y[i] != 16 + r * 16) begin
                n_err++;
                $display("FAIL full_cell%0d: got ms %0d t %0d x %0d y %0d need 3 %0d %0d %0d",
                         i - 1, q_ms[i], q_tile[i], q_x[i], q_y[i],
                         mdl[i - 1], 40 + c * 16, 16 + r * 16);
            end
        end
        n_cmp++;
        if (frames != f0 + 1) begin
            n_err++;
            $display("FAIL full_frames: got %0d need %0d", frames - f0, 1);
        end
    endtask

    task automatic test_single_write();
        clear_q();
        write_cell(3, 2, 5);
        wait_frames(1, 2000);
        wait_idle(200);
        n_cmp++;
        if (q_ms.size() != 1) begin
            n_err++;
            $display("FAIL single_count: got %0d need 1", q_ms.size());
        end else begin
            n_cmp++;
            if (q_ms[0] != 3 || q_tile[0] != 5 || q_x[0] != 40 + 3 * 16
                || q_y[0] != 16 + 2 * 16) begin
                n_err++;
                $display("FAIL single_go: got ms %0d t %0d x %0d y %0d need 3 5 88 48",
                         q_ms[0], q_tile[0], q_x[0], q_y[0]);
            end
        end
        rd_col = 4'd3;
        rd_row = 4'd2;
        #1;
        n_cmp++;
        if (int'(rd_tile) != mdl[2 * COLS + 3]) begin
            n_err++;
            $display("FAIL single_rd: got %0d need %0d", rd_tile, mdl[2 * COLS + 3]);
        end
    endtask

    task automatic test_ignored_writes();
        clear_q();
        busy_seen = 1'b0;
        write_cell(15, 0, 7);
        write_cell(3, 2, mdl[2 * COLS + 3]);
        write_cell(2, 13, 9);
        repeat (20) @(negedge clk);
        n_cmp += 2;
        if (busy_seen) begin
            n_err++; $display("FAIL ign_busy: got busy 1 need 0");
        end
        if (q_ms.size() != 0) begin
            n_err++; $display("FAIL ign_go: got %0d gos need 0", q_ms.size());
        end
        rd_col = 4'd15;
        rd_row = 4'd0;
        #1;
        n_cmp++;
        if (rd_tile !== 4'd0) begin
            n_err++; $display("FAIL ign_rd15: got %0d need 0", rd_tile);
        end
        rd_col = 4'd2;
        rd_row = 4'd13;
        #1;
        n_cmp++;
        if (rd_tile !== 4'd0) begin
            n_err++; $display("FAIL ign_rd13: got %0d need 0", rd_tile);
        end
    endtask

    task automatic test_write_during_wait();
        int f0;
        write_cell(3, 2, 12);
        wait_frames(1, 2000);
        wait_idle(200);
        clear_q();
        f0 = frames;
        write_cell(3, 2, 5);
        wait_go(500);
        write_cell(3, 2, 9);
        wait_frames(2, 4000);
        wait_idle(200);
        n_cmp++;
        if (q_ms.size() != 2) begin
            n_err++;
            $display("FAIL wdw_count: got %0d need 2", q_ms.size());
        end else begin
            n_cmp += 2;
            if (q_tile[0] != 5 || q_x[0] != 88 || q_y[0] != 48 || q_fr[0] != f0) begin
                n_err++;
                $display("FAIL wdw_first: got t %0d x %0d y %0d f %0d need 5 88 48 %0d",
                         q_tile[0], q_x[0], q_y[0], q_fr[0], f0);
            end
            if (q_tile[1] != 9 || q_x[1] != 88 || q_y[1] != 48
                || q_fr[1] != f0 + 1) begin
                n_err++;
                $display("FAIL wdw_second: got t %0d x %0d y %0d f %0d need 9 88 48 %0d",
                         q_tile[1], q_x[1], q_y[1], q_fr[1], f0 + 1);
            end
        end
        n_cmp++;
        if (frames != f0 + 2) begin
            n_err++;
            $display("FAIL wdw_frames: got %0d need 2", frames - f0);
        end
    endtask

    task automatic test_redraw_mid_pass();
        int f0;
        int t1;
        int t2;
        int bad;
        t1 = (mdl[0] + 1) % 16;
        t2 = (mdl[N - 1] + 3) % 16;
        clear_q();
        f0 = frames;
        write_cell(0, 0, t1);
        write_cell(14, 12, t2);
        @(negedge clk);
        redraw_all = 1'b1;
        @(negedge clk);
        redraw_all = 1'b0;
        wait_frames(2, 8000);
        wait_idle(200);
        n_cmp++;
        if (q_ms.size() != N + 3) begin
            n_err++;
            $display("FAIL rdr_count: got %0d need %0d", q_ms.size(), N + 3);
        end else begin
            n_cmp += 3;
            if (q_ms[0] != 3 || q_tile[0] != t1 || q_x[0] != 40 || q_y[0] != 16
                || q_fr[0] != f0) begin
                n_err++;
                $display("FAIL rdr_first: got ms %0d t %0d x %0d y %0d need 3 %0d 40 16",
                         q_ms[0], q_tile[0], q_x[0], q_y[0], t1);
            end
            if (q_ms[1] != 3 || q_tile[1] != t2 || q_x[1] != 264 || q_y[1] != 208
                || q_fr[1] != f0) begin
                n_err++;
                $display("FAIL rdr_last: got ms %0d t %0d x %0d y %0d need 3 %0d 264 208",
                         q_ms[1], q_tile[1], q_x[1], q_y[1], t2);
            end
            if (q_ms[2] != 1 || q_fr[2] != f0 + 1) begin
                n_err++;
                $display("FAIL rdr_bg: got ms %0d frame %0d need 1 %0d",
                         q_ms[2], q_fr[2], f0 + 1);
            end
            bad = 0;
            for (int i = 3; i < N + 3; i++)
                if (q_ms[i] != 3 || q_tile[i] != mdl[i - 3]) bad++;
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL rdr_cells: got %0d wrong cell draws need 0", bad);
            end
        end
        bad = 0;
        foreach (scr[i]) if (scr[i] != mdl[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rdr_screen: got %0d stale cells need 0", bad);
        end
    endtask

    task automatic test_random();
        int bad;
        int nbg;
        clear_q();
        rand_delay = 1'b1;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            write_cell(int'($urandom_range(0, 15)), int'($urandom_range(0, 13)),
                       int'($urandom_range(0, 15)));
        end
        wait_idle(20000);
        rand_delay = 1'b0;
        bad = 0;
        foreach (scr[i]) if (scr[i] != mdl[i]) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rnd_screen: got %0d stale cells need 0", bad);
        end
        nbg = 0;
        foreach (q_ms[i]) if (q_ms[i] != 3) nbg++;
        n_cmp++;
        if (nbg != 0) begin
            n_err++;
            $display("FAIL rnd_ms: got %0d non-tile copies need 0", nbg);
        end
        for (int k = 0; k < 20; k++) begin
            int c;
            int r;
            int e;
            c = int'($urandom_range(0, 15));
            r = int'($urandom_range(0, 15));
            e = (c < COLS && r < ROWS) ? mdl[r * COLS + c] : 0;
            rd_col = 4'(c);
            rd_row = 4'(r);
            #1;
            n_cmp++;
            if (int'(rd_tile) != e) begin
                n_err++;
                $display("FAIL rnd_rd(%0d,%0d): got %0d need %0d", c, r, rd_tile, e);
            end
        end
    endtask

    task automatic test_reset_during_wait();
        int bad;
        write_cell(5, 5, (mdl[5 * COLS + 5] + 1) % 16);
        wait_go(500);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        rd_col = 4'd5;
        rd_row = 4'd5;
        #1;
        n_cmp += 4;
        if (copy_go !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL arst_ctl: got go %b busy %b fd %b need 0 0 0",
                     copy_go, busy, frame_done);
        end
        if (copy_memory_select !== 2'b11 || copy_tile_select !== 4'd0) begin
            n_err++;
            $display("FAIL arst_sel: got ms %b t %0d need 11 0",
                     copy_memory_select, copy_tile_select);
        end
        if (copy_x !== 9'd0 || copy_y !== 8'd0) begin
            n_err++;
            $display("FAIL arst_xy: got %0d %0d need 0 0", copy_x, copy_y);
        end
        if (rd_tile !== 4'd0) begin
            n_err++;
            $display("FAIL arst_rd: got %0d need 0", rd_tile);
        end
        foreach (mdl[i]) mdl[i] = 0;
        @(negedge clk);
        test_full_redraw();
        bad = 0;
        foreach (scr[i]) if (scr[i] != 0) bad++;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL arst_screen: got %0d non-zero cells need 0", bad);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        cell_we = 1'b0;
        cell_col = 4'd0;
        cell_row = 4'd0;
        cell_tile = 4'd0;
        rd_col = 4'd0;
        rd_row = 4'd0;
        redraw_all = 1'b0;
        copy_finished = 1'b0;
        foreach (mdl[i]) mdl[i] = 0;
        foreach (scr[i]) scr[i] = -2;
        test_reset();
        test_full_redraw();
        test_single_write();
        test_ignored_writes();
        test_write_during_wait();
        test_redraw_mid_pass();
        test_random();
        test_reset_during_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
